ysyx_22051468_mdu: RTL and testbench

Iterative RV64M multiply/divide unit for the execute stage. It handles every instruction decode flags as `is_mul`/`is_div`/`is_rem`, which the general ALU path excludes. A single shared shift datapath runs a bit-serial multiply or divide, parametrised in operand width. The unit stalls the pipeline through `hold_pipeline_en` until its result is written back.

---
 rtl/ysyx_22051468_mdu_pkg.sv | 32 +++
 rtl/ysyx_22051468_mdu_step.sv | 48 ++++
 rtl/ysyx_22051468_mdu.sv | 170 +++++++++++++++++
 tb/tb_ysyx_22051468_mdu.sv | 361 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ysyx_22051468_mdu_pkg.sv
// Shared definitions for the RV64M multiply/divide unit.
//   - MDU funct3 codes as decoded from the instruction
//   - FSM state encoding (2 bits)
//   - operand signedness helpers keyed on funct3
package ysyx_22051468_mdu_pkg;

    localparam logic [2:0] MDU_MUL    = 3'b000;
    localparam logic [2:0] MDU_MULH   = 3'b001;
    localparam logic [2:0] MDU_MULHSU = 3'b010;
    localparam logic [2:0] MDU_MULHU  = 3'b011;
    localparam logic [2:0] MDU_DIV    = 3'b100;
    localparam logic [2:0] MDU_DIVU   = 3'b101;
    localparam logic [2:0] MDU_REM    = 3'b110;
    localparam logic [2:0] MDU_REMU   = 3'b111;

    typedef enum logic [1:0] {
        MDU_IDLE = 2'd0,
        MDU_CALC = 2'd1,
        MDU_DONE = 2'd2
    } mdu_state_e;

    function automatic logic op_rs1_signed(input logic [2:0] op);
        return (op == MDU_MUL) || (op == MDU_MULH) || (op == MDU_MULHSU) ||
               (op == MDU_DIV) || (op == MDU_REM);
    endfunction

    function automatic logic op_rs2_signed(input logic [2:0] op);
        return (op == MDU_MUL) || (op == MDU_MULH) ||
               (op == MDU_DIV) || (op == MDU_REM);
    endfunction

endpackage

// File: rtl/ysyx_22051468_mdu_step.sv
// One iteration of the shared bit-serial datapath.
//   is_div  : 1 = restoring-divide step, 0 = shift-add multiply step
//   is_w    : operand width is WORD instead of WIDTH (selects the scanned bit)
//   acc_i   : 2*WIDTH accumulator (product, or remainder in the low half)
//   shreg_i : multiplier / dividend shift register (quotient shifts in at LSB)
//   opnd_i  : multiplicand / divisor magnitude
//   acc_o, shreg_o : values after this iteration
module ysyx_22051468_mdu_step #(
    parameter int WIDTH = 64,
    parameter int WORD  = 32
) (
    input  logic                 is_div,
    input  logic                 is_w,
    input  logic [2*WIDTH-1:0]   acc_i,
    input  logic [WIDTH-1:0]     shreg_i,
    input  logic [WIDTH-1:0]     opnd_i,
    output logic [2*WIDTH-1:0]   acc_o,
    output logic [WIDTH-1:0]     shreg_o
);

    logic             top_bit;
    logic [WIDTH:0]   trial;
    logic [WIDTH:0]   diff;

    always_comb begin
        // Both algorithms consume the operand MSB-first; for word ops the
        // MSB sits at WORD-1 since the magnitude is zero above it.
        top_bit = is_w ? shreg_i[WORD-1] : shreg_i[WIDTH-1];
        trial   = {acc_i[WIDTH-1:0], top_bit};
        diff    = trial - {1'b0, opnd_i};
        acc_o   = '0;
        shreg_o = {shreg_i[WIDTH-2:0], 1'b0};
        if (is_div) begin
            // Remainder stays below the divisor, so a borrow out of the
            // extra bit means the trial subtraction must be restored.
            if (!diff[WIDTH]) begin
                acc_o   = {{WIDTH{1'b0}}, diff[WIDTH-1:0]};
                shreg_o = {shreg_i[WIDTH-2:0], 1'b1};
            end else begin
                acc_o   = {{WIDTH{1'b0}}, trial[WIDTH-1:0]};
            end
        end else begin
            acc_o = {acc_i[2*WIDTH-2:0], 1'b0} +
                    (top_bit ? {{WIDTH{1'b0}}, opnd_i} : {2*WIDTH{1'b0}});
        end
    end

endmodule

// File: rtl/ysyx_22051468_mdu.sv
// Iterative RV64M multiply/divide unit (execute stage).
// Ports:
//   clk, rst                : clock, synchronous active-high reset
//   valid_i / ready_o       : request handshake (ready_o = IDLE decode)
//   op_i, is_W_i            : funct3 and word-variant flag
//   rs1_data_i, rs2_data_i  : operands
//   rd_addr_i               : destination register, returned as w_addr_o
//   flush_i                 : abort the in-flight op
//   valid_o / ready_i       : result handshake with writeback
//   w_addr_en, w_addr_o, w_data_o : registered writeback
//   hold_pipeline_en        : stall request while the op is outstanding
module ysyx_22051468_mdu
    import ysyx_22051468_mdu_pkg::*;
#(
    parameter int WIDTH = 64,
    parameter int WORD  = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              valid_i,
    output logic              ready_o,
    input  logic [2:0]        op_i,
    input  logic              is_W_i,
    input  logic [WIDTH-1:0]  rs1_data_i,
    input  logic [WIDTH-1:0]  rs2_data_i,
    input  logic [4:0]        rd_addr_i,
    input  logic              flush_i,
    output logic              valid_o,
    input  logic              ready_i,
    output logic              w_addr_en,
    output logic [4:0]        w_addr_o,
    output logic [WIDTH-1:0]  w_data_o,
    output logic              hold_pipeline_en
);

    localparam int AW = 2 * WIDTH;
    localparam int CW = $clog2(WIDTH);
    localparam int SH = WIDTH - WORD;

    // Sign- or zero-extend the low WORD bits when w is set.
    function automatic logic signed [WIDTH-1:0] extend(input logic [WIDTH-1:0] x,
                                                       input logic w, input logic sgn);
        logic signed [WIDTH-1:0] t;
        t = x << SH;
        if (!w) return x;
        return sgn ? (t >>> SH) : (t >> SH);
    endfunction

    // Sign fix-up and result selection applied on the last iteration.
    function automatic logic [WIDTH-1:0] fixup(input logic [2:0] op, input logic w,
                                               input logic neg, input logic neg_r,
                                               input logic [AW-1:0] prod,
                                               input logic [WIDTH-1:0] quo,
                                               input logic [WIDTH-1:0] rem);
        logic [AW-1:0]    prod_s;
        logic [WIDTH-1:0] res;
        prod_s = neg ? -prod : prod;
        case (op)
            MDU_MUL:                         res = prod_s[WIDTH-1:0];
            MDU_MULH, MDU_MULHSU, MDU_MULHU: res = prod_s[AW-1:WIDTH];
            MDU_DIV, MDU_DIVU:               res = neg ? -quo : quo;
            default:                         res = neg_r ? -rem : rem;
        endcase
        return w ? extend(res, 1'b1, 1'b1) : res;
    endfunction

    mdu_state_e              state_q, state_d;
    logic [CW-1:0]           cnt_q;
    logic [2:0]              op_q;
    logic                    w_q, neg_q, neg_r_q;
    logic [WIDTH-1:0]        shreg_q, opnd_q, shreg_nx;
    logic [AW-1:0]           acc_q, acc_nx;

    logic                    accept, calc_last;
    logic                    eff_w, s1_sgn, s2_sgn, neg1, neg2, div0, ovf, special;
    logic [2:0]              op_eff;
    logic signed [WIDTH-1:0] a1, a2, min_ext;
    logic [WIDTH-1:0]        mag1, mag2, spec_res;
    logic [CW-1:0]           cnt_init;

    // Request decode: operand extension, magnitudes, special cases.
    always_comb begin
        eff_w    = is_W_i && (WIDTH == 64);
        op_eff   = (eff_w && !op_i[2]) ? MDU_MUL : op_i;  // mulh*w runs as mulw
        s1_sgn   = op_rs1_signed(op_eff);
        s2_sgn   = op_rs2_signed(op_eff);
        a1       = extend(rs1_data_i, eff_w, s1_sgn);
        a2       = extend(rs2_data_i, eff_w, s2_sgn);
        neg1     = s1_sgn && a1[WIDTH-1];
        neg2     = s2_sgn && a2[WIDTH-1];
        mag1     = neg1 ? -a1 : a1;
        mag2     = neg2 ? -a2 : a2;
        min_ext  = {WIDTH{1'b1}} << (eff_w ? WORD - 1 : WIDTH - 1);
        div0     = op_eff[2] && (a2 == '0);
        ovf      = op_eff[2] && s1_sgn && (a1 == min_ext) && (a2 == '1);
        special  = div0 || ovf;
        if (op_eff[1]) spec_res = div0 ? extend(rs1_data_i, eff_w, 1'b1) : '0;
        else           spec_res = div0 ? '1 : min_ext;
        cnt_init = eff_w ? CW'(WORD - 1) : CW'(WIDTH - 1);
    end

    assign accept    = (state_q == MDU_IDLE) && valid_i && !flush_i;
    assign calc_last = (state_q == MDU_CALC) && (cnt_q == '0);

    ysyx_22051468_mdu_step #(.WIDTH(WIDTH), .WORD(WORD)) u_step (
        .is_div  (op_q[2]),
        .is_w    (w_q),
        .acc_i   (acc_q),
        .shreg_i (shreg_q),
        .opnd_i  (opnd_q),
        .acc_o   (acc_nx),
        .shreg_o (shreg_nx)
    );

    always_comb begin
        state_d = state_q;
        case (state_q)
            MDU_IDLE: if (accept) state_d = special ? MDU_DONE : MDU_CALC;
            MDU_CALC: begin
                if (flush_i)        state_d = MDU_IDLE;
                else if (calc_last) state_d = MDU_DONE;
            end
            MDU_DONE: if (flush_i || ready_i) state_d = MDU_IDLE;
            default:  state_d = MDU_IDLE;
        endcase
    end

    // Control and writeback registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= MDU_IDLE;
            w_addr_o <= '0;
            w_data_o <= '0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                w_addr_o <= rd_addr_i;
                if (special) w_data_o <= spec_res;
            end else if (calc_last && !flush_i) begin
                w_data_o <= fixup(op_q, w_q, neg_q, neg_r_q, acc_nx,
                                  shreg_nx, acc_nx[WIDTH-1:0]);
            end
        end
    end

    // Iteration datapath registers.
    always_ff @(posedge clk) begin
        if (accept) begin
            op_q    <= op_eff;
            w_q     <= eff_w;
            neg_q   <= neg1 ^ neg2;
            neg_r_q <= neg1;
            shreg_q <= mag1;
            opnd_q  <= mag2;
            acc_q   <= '0;
            cnt_q   <= cnt_init;
        end else if (state_q == MDU_CALC) begin
            shreg_q <= shreg_nx;
            acc_q   <= acc_nx;
            cnt_q   <= cnt_q - CW'(1);
        end
    end

    assign ready_o          = (state_q == MDU_IDLE);
    assign valid_o          = (state_q == MDU_DONE);
    assign w_addr_en        = valid_o;
    assign hold_pipeline_en = accept || (state_q == MDU_CALC) ||
                              ((state_q == MDU_DONE) && !ready_i);

endmodule

// File: tb/tb_ysyx_22051468_mdu.sv
module tb_ysyx_22051468_mdu;

    logic        clk = 1'b0;
    logic        rst, valid_i, ready_o, is_W_i, flush_i, valid_o, ready_i;
    logic        w_addr_en, hold_pipeline_en;
    logic [2:0]  op_i;
    logic [63:0] rs1_data_i, rs2_data_i, w_data_o;
    logic [4:0]  rd_addr_i, w_addr_o;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    ysyx_22051468_mdu #(.WIDTH(64), .WORD(32)) dut (
        .clk(clk), .rst(rst), .valid_i(valid_i), .ready_o(ready_o), .op_i(op_i),
        .is_W_i(is_W_i), .rs1_data_i(rs1_data_i), .rs2_data_i(rs2_data_i),
        .rd_addr_i(rd_addr_i), .flush_i(flush_i), .valid_o(valid_o), .ready_i(ready_i),
        .w_addr_en(w_addr_en), .w_addr_o(w_addr_o), .w_data_o(w_data_o),
        .hold_pipeline_en(hold_pipeline_en)
    );

    // Reference: RISC-V M-extension semantics with wide plain arithmetic.
    function automatic logic [63:0] model(input logic [2:0] op, input logic w,
                                          input logic [63:0] a, input logic [63:0] b);
        logic signed [127:0] sp;
        logic [127:0]        up;
        longint              sa, sb;
        int                  wa, wb, wr;
        int unsigned         uwa, uwb;
        sa = a; sb = b; wa = a[31:0]; wb = b[31:0]; uwa = a[31:0]; uwb = b[31:0];
        if (w) begin
            case (op)
                3'b100: wr = (wb == 0) ? -1 : (wb == -1) ? -wa : wa / wb;
                3'b101: wr = (uwb == 0) ? -1 : int'(uwa / uwb);
                3'b110: wr = (wb == 0) ? wa : (wb == -1) ? 0 : wa % wb;
                3'b111: wr = (uwb == 0) ? wa : int'(uwa % uwb);
                default: wr = wa * wb;
            endcase
            return {{32{wr[31]}}, wr};
        end
        case (op)
            3'b000: return a * b;
            3'b001: begin
                sp = $signed({{64{a[63]}}, a}) * $signed({{64{b[63]}}, b});
                return sp[127:64];
            end
            3'b010: begin
                sp = $signed({{64{a[63]}}, a}) * $signed({64'd0, b});
                return sp[127:64];
            end
            3'b011: begin
                up = {64'd0, a} * {64'd0, b};
                return up[127:64];
            end
            3'b100: return (b == 0) ? '1 : (sb == -1) ? 64'(-sa) : 64'(sa / sb);
            3'b101: return (b == 0) ? '1 : a / b;
            3'b110: return (b == 0) ? a : (sb == -1) ? 64'd0 : 64'(sa % sb);
            default: return (b == 0) ? a : a % b;
        endcase
    endfunction

    function automatic int lat_model(input logic [2:0] op, input logic w,
                                     input logic [63:0] a, input logic [63:0] b);
        logic zero, ovf, sgn;
        sgn = (op == 3'b100) || (op == 3'b110);
        if (w) begin
            zero = (b[31:0] == 32'd0);
            ovf  = sgn && (a[31:0] == 32'h8000_0000) && (b[31:0] == 32'hFFFF_FFFF);
        end else begin
            zero = (b == 64'd0);
            ovf  = sgn && (a == 64'h8000_0000_0000_0000) && (b == '1);
        end
        if (op[2] && (zero || ovf)) return 1;
        return w ? 33 : 65;
    endfunction

    function automatic logic [63:0] pick_operand();
        logic [63:0] r;
        r = {$urandom(), $urandom()};
        case ($urandom_range(0, 7))
            0: r = 64'd0;
            1: r = '1;
            2: r = 64'h8000_0000_0000_0000;
            3: r = 64'($urandom_range(0, 20));
            4: r[31:0] = 32'h8000_0000;
            5: r[31:0] = 32'hFFFF_FFFF;
            default: ;
        endcase
        return r;
    endfunction

    // Issue one request with ready_i=1; reports cycles to valid_o (T+lat),
    // captured result, and whether handshake/stall behaviour was as expected.
    task automatic do_op(input logic [2:0] op, input logic w, input logic [63:0] a,
                         input logic [63:0] b, input logic [4:0] rd,
                         output int lat, output logic [63:0] data,
                         output logic [4:0] addr, output logic ctl_ok);
        ctl_ok = 1'b1;
        op_i = op; is_W_i = w; rs1_data_i = a; rs2_data_i = b; rd_addr_i = rd;
        ready_i = 1'b1; valid_i = 1'b1;
        #1;
        if (!hold_pipeline_en || !ready_o) ctl_ok = 1'b0;
        @(posedge clk); #1;
        valid_i = 1'b0;
        rs1_data_i = {$urandom(), $urandom()};
        rs2_data_i = {$urandom(), $urandom()};
        rd_addr_i  = 5'($urandom());
        lat = 1;
        while (!valid_o && lat < 200) begin
            if (!hold_pipeline_en || ready_o) ctl_ok = 1'b0;
            @(posedge clk); #1;
            lat++;
        end
        if (hold_pipeline_en || !w_addr_en) ctl_ok = 1'b0;
        data = w_data_o;
        addr = w_addr_o;
        @(posedge clk); #1;
        if (valid_o || !ready_o) ctl_ok = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        @(posedge clk); #1;
        n_cmp++;
        if ({ready_o, valid_o, w_addr_en, hold_pipeline_en} !== 4'b1000 ||
            w_addr_o !== 5'd0 || w_data_o !== 64'd0) begin
            n_err++;
            $display("FAIL reset: rdy/vld/en/hold=%b addr=%0d data=%h required 1000/0/0",
                     {ready_o, valid_o, w_addr_en, hold_pipeline_en}, w_addr_o, w_data_o);
        end
        rst = 1'b0;
        @(posedge clk); #1;
        n_cmp++;
        if (ready_o !== 1'b1 || valid_o !== 1'b0) begin
            n_err++;
            $display("FAIL reset_release: ready=%b valid=%b required 1/0", ready_o, valid_o);
        end
    endtask

    typedef struct {
        logic [2:0]  op;
        logic        w;
        logic [63:0] a, b, exp;
        int          lat;
    } vec_t;

    task automatic test_directed();
        vec_t        v[$];
        int          lat;
        logic [63:0] d;
        logic [4:0]  ad;
        logic        ok;
        v.push_back('{3'b000, 1'b0, 64'd7, 64'hFFFF_FFFF_FFFF_FFFD, 64'hFFFF_FFFF_FFFF_FFEB, 65});
        v.push_back('{3'b011, 1'b0, '1, '1, 64'hFFFF_FFFF_FFFF_FFFE, 65});
        v.push_back('{3'b010, 1'b0, '1, 64'd2, '1, 65});
        v.push_back('{3'b100, 1'b0, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFD, 65});
        v.push_back('{3'b110, 1'b0, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, '1, 65});
        v.push_back('{3'b101, 1'b0, 64'd100, 64'd7, 64'd14, 65});
        v.push_back('{3'b111, 1'b0, 64'd100, 64'd7, 64'd2, 65});
        v.push_back('{3'b101, 1'b0, 64'd5, 64'd0, '1, 1});
        v.push_back('{3'b110, 1'b0, 64'd5, 64'd0, 64'd5, 1});
        v.push_back('{3'b100, 1'b0, 64'h8000_0000_0000_0000, '1, 64'h8000_0000_0000_0000, 1});
        v.push_back('{3'b110, 1'b0, 64'h8000_0000_0000_0000, '1, 64'd0, 1});
        v.push_back('{3'b100, 1'b1, 64'h0000_0000_8000_0000, '1, 64'hFFFF_FFFF_8000_0000, 1});
        v.push_back('{3'b101, 1'b1, 64'h0000_0000_FFFF_FFFF, 64'd1, '1, 33});
        v.push_back('{3'b001, 1'b1, 64'h0000_0001_0000_0003, 64'd5, 64'd15, 33});
        foreach (v[i]) begin
            do_op(v[i].op, v[i].w, v[i].a, v[i].b, 5'(i + 1), lat, d, ad, ok);
            n_cmp++;
            if (d !== v[i].exp) begin
                n_err++;
                $display("FAIL directed[%0d] data: got %h required %h", i, d, v[i].exp);
            end
            n_cmp++;
            if (lat != v[i].lat || ad !== 5'(i + 1) || ok !== 1'b1) begin
                n_err++;
                $display("FAIL directed[%0d] timing: lat=%0d addr=%0d ctl=%b required lat=%0d addr=%0d ctl=1",
                         i, lat, ad, ok, v[i].lat, i + 1);
            end
        end
    endtask

    task automatic test_random();
        int          lat;
        logic [63:0] a, b, d;
        logic [4:0]  rd, ad;
        logic [2:0]  op;
        logic        w, ok;
        for (int i = 0; i < 40; i++) begin
            op = 3'($urandom());
            w  = ($urandom_range(0, 2) == 0);
            a  = pick_operand();
            b  = pick_operand();
            rd = 5'($urandom());
            do_op(op, w, a, b, rd, lat, d, ad, ok);
            n_cmp++;
            if (d !== model(op, w, a, b) || lat != lat_model(op, w, a, b) ||
                ad !== rd || ok !== 1'b1) begin
                n_err++;
                $display("FAIL random[%0d] op=%0d w=%b a=%h b=%h: got %h lat=%0d addr=%0d ctl=%b required %h lat=%0d addr=%0d ctl=1",
                         i, op, w, a, b, d, lat, ad, ok, model(op, w, a, b),
                         lat_model(op, w, a, b), rd);
            end
        end
    endtask

    task automatic test_flush();
        logic seen;
        ready_i = 1'b1;
        op_i = 3'b000; is_W_i = 1'b0; rs1_data_i = 64'd9; rs2_data_i = 64'd9;
        rd_addr_i = 5'd3; valid_i = 1'b1;
        @(posedge clk); #1;
        valid_i = 1'b0;
        repeat (9) @(posedge clk);
        #1;
        flush_i = 1'b1;
        @(posedge clk); #1;
        flush_i = 1'b0;
        n_cmp++;
        if (ready_o !== 1'b1 || valid_o !== 1'b0) begin
            n_err++;
            $display("FAIL flush_calc: ready=%b valid=%b required 1/0", ready_o, valid_o);
        end
        seen = 1'b0;
        repeat (70) begin
            if (valid_o) seen = 1'b1;
            @(posedge clk); #1;
        end
        n_cmp++;
        if (seen !== 1'b0) begin
            n_err++;
            $display("FAIL flush_no_result: valid_seen=%b required 0", seen);
        end
        // Flush has priority over a same-cycle request.
        op_i = 3'b101; rs2_data_i = 64'd0; valid_i = 1'b1; flush_i = 1'b1;
        #1;
        n_cmp++;
        if (hold_pipeline_en !== 1'b0) begin
            n_err++;
            $display("FAIL flush_beats_valid_hold: hold=%b required 0", hold_pipeline_en);
        end
        @(posedge clk); #1;
        valid_i = 1'b0; flush_i = 1'b0;
        n_cmp++;
        if (ready_o !== 1'b1 || valid_o !== 1'b0) begin
            n_err++;
            $display("FAIL flush_beats_valid: ready=%b valid=%b required 1/0", ready_o, valid_o);
        end
        // Flush while holding a result in DONE.
        ready_i = 1'b0; valid_i = 1'b1;
        @(posedge clk); #1;
        valid_i = 1'b0; flush_i = 1'b1;
        @(posedge clk); #1;
        flush_i = 1'b0; ready_i = 1'b1;
        n_cmp++;
        if (valid_o !== 1'b0 || ready_o !== 1'b1) begin
            n_err++;
            $display("FAIL flush_done: valid=%b ready=%b required 0/1", valid_o, ready_o);
        end
    endtask

    task automatic test_backpressure();
        int guard;
        ready_i = 1'b0;
        op_i = 3'b101; is_W_i = 1'b0; rs1_data_i = 64'd100; rs2_data_i = 64'd7;
        rd_addr_i = 5'd9; valid_i = 1'b1;
        @(posedge clk); #1;
        valid_i = 1'b0;
        guard = 0;
        while (!valid_o && guard < 200) begin
            @(posedge clk); #1;
            guard++;
        end
        n_cmp++;
        if (valid_o !== 1'b1 || guard != 64) begin
            n_err++;
            $display("FAIL bp_latency: valid=%b cycles=%0d required 1/64", valid_o, guard);
        end
        for (int k = 0; k < 3; k++) begin
            n_cmp++;
            if (w_data_o !== 64'd14 || w_addr_o !== 5'd9 || valid_o !== 1'b1 ||
                hold_pipeline_en !== 1'b1) begin
                n_err++;
                $display("FAIL bp_hold[%0d]: data=%h addr=%0d valid=%b hold=%b required 14/9/1/1",
                         k, w_data_o, w_addr_o, valid_o, hold_pipeline_en);
            end
            @(posedge clk); #1;
        end
        ready_i = 1'b1;
        #1;
        n_cmp++;
        if (hold_pipeline_en !== 1'b0 || valid_o !== 1'b1) begin
            n_err++;
            $display("FAIL bp_release: hold=%b valid=%b required 0/1", hold_pipeline_en, valid_o);
        end
        @(posedge clk); #1;
        n_cmp++;
        if (valid_o !== 1'b0 || ready_o !== 1'b1) begin
            n_err++;
            $display("FAIL bp_handshake: valid=%b ready=%b required 0/1", valid_o, ready_o);
        end
    endtask

    task automatic test_rst_mid();
        ready_i = 1'b1;
        op_i = 3'b000; is_W_i = 1'b0; rs1_data_i = 64'd11; rs2_data_i = 64'd13;
        rd_addr_i = 5'd17; valid_i = 1'b1;
        @(posedge clk); #1;
        valid_i = 1'b0;
        repeat (20) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        n_cmp++;
        if ({ready_o, valid_o, w_addr_en, hold_pipeline_en} !== 4'b1000 ||
            w_addr_o !== 5'd0 || w_data_o !== 64'd0) begin
            n_err++;
            $display("FAIL rst_mid: rdy/vld/en/hold=%b addr=%0d data=%h required 1000/0/0",
                     {ready_o, valid_o, w_addr_en, hold_pipeline_en}, w_addr_o, w_data_o);
        end
    endtask

    task automatic test_back_to_back();
        int          lat;
        logic [63:0] d;
        logic [4:0]  ad;
        logic        ok;
        do_op(3'b111, 1'b1, 64'hDEAD_0000_0000_0064, 64'h1234_0000_0000_0009, 5'd21, lat, d, ad, ok);
        n_cmp++;
        if (d !== 64'd1 || lat != 33 || ad !== 5'd21 || ok !== 1'b1) begin
            n_err++;
            $display("FAIL b2b_first: data=%h lat=%0d addr=%0d ctl=%b required 1/33/21/1", d, lat, ad, ok);
        end
        do_op(3'b001, 1'b0, 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 5'd22, lat, d, ad, ok);
        n_cmp++;
        if (d !== 64'h4000_0000_0000_0000 || lat != 65 || ad !== 5'd22 || ok !== 1'b1) begin
            n_err++;
            $display("FAIL b2b_second: data=%h lat=%0d addr=%0d ctl=%b required 4000000000000000/65/22/1",
                     d, lat, ad, ok);
        end
    endtask

    initial begin
        rst = 1'b1; valid_i = 1'b0; flush_i = 1'b0; ready_i = 1'b1; is_W_i = 1'b0;
        op_i = 3'b000; rs1_data_i = '0; rs2_data_i = '0; rd_addr_i = '0;
        repeat (3) @(posedge clk);
        #1;
        test_reset();
        test_directed();
        test_random();
        test_flush();
        test_backpressure();
        test_rst_mid();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
